dma_rx_endpoint: RTL and testbench

//   Peripheral-side DMA endpoint on the Brew V1 external bus, downstream of the CPU pins. Buffers bytes

---
 rtl/brew_dma_pkg.sv | 13 +
 rtl/brew_sync_fifo.sv | 49 ++++
 rtl/dma_rx_endpoint.sv | 147 ++++++++++++++
 tb/tb_dma_rx_endpoint.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brew_dma_pkg.sv
// Shared types and constants for the Brew V1 peripheral DMA endpoint.
package brew_dma_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_XFER,
        DMA_DONE
    } dma_ep_state_e;

    localparam int unsigned DMA_DATA_W    = 8;
    localparam logic [7:0]  DMA_IDLE_DATA = 8'h00;

endpackage

// File: rtl/brew_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is the oldest entry, read without a pop.
module brew_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dma_rx_endpoint.sv
// Peripheral-side DMA endpoint: buffers source bytes, requests the CPU DMA channel, drives
// the head byte during the acknowledge and raises a level interrupt on terminal count.
module dma_rx_endpoint
    import brew_dma_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned REQ_THRESHOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     drq,
    input  logic                     n_dack,
    input  logic                     tc,
    input  logic                     n_we,
    output logic [7:0]               data_out,
    output logic                     data_out_en,
    output logic                     n_irq,
    input  logic                     irq_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic                     dir_err
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    dma_ep_state_e         state;
    dma_ep_state_e         state_next;
    logic                  tc_seen;
    logic                  tc_seen_next;
    logic                  we_bad;
    logic                  we_bad_next;
    logic                  flush_pend;
    logic                  flush_pend_next;
    logic                  underrun_set;
    logic                  dir_err_set;
    logic                  drq_next;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DMA_DATA_W-1:0] head;
    logic [LW-1:0]         level_next;

    brew_sync_fifo #(
        .WIDTH (DMA_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign push = in_valid & in_ready & ~full;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= DMA_IDLE;
        else      state <= state_next;
    end

    // Transfer sequencing: tc and direction are accumulated over every n_dack-low cycle,
    // and the single pop is decided on the n_dack rising edge.
    always_comb begin
        state_next   = state;
        tc_seen_next = tc_seen;
        we_bad_next  = we_bad;
        pop          = 1'b0;
        underrun_set = 1'b0;
        dir_err_set  = 1'b0;
        case (state)
            DMA_IDLE: begin
                if (!n_dack) begin
                    state_next   = DMA_XFER;
                    tc_seen_next = tc;
                    we_bad_next  = n_we;
                end
            end
            DMA_XFER: begin
                if (!n_dack) begin
                    tc_seen_next = tc_seen | tc;
                    we_bad_next  = we_bad | n_we;
                end else begin
                    state_next   = tc_seen ? DMA_DONE : DMA_IDLE;
                    pop          = ~empty & ~we_bad;
                    underrun_set = empty;
                    dir_err_set  = we_bad;
                end
            end
            DMA_DONE: begin
                if (irq_clr) state_next = DMA_IDLE;
            end
            default: state_next = DMA_IDLE;
        endcase
    end

    assign level_next = level + LW'(push) - LW'(pop);

    // Flush request survives until the FIFO drains or a terminal count ends the block.
    always_comb begin
        flush_pend_next = flush_pend;
        if ((level_next == '0) || (state_next == DMA_DONE && state != DMA_DONE)) begin
            flush_pend_next = 1'b0;
        end else if (flush && (level != '0)) begin
            flush_pend_next = 1'b1;
        end
    end

    assign drq_next = (state_next == DMA_IDLE)
                    & ((level_next >= LW'(REQ_THRESHOLD))
                       | (flush_pend_next & (level_next != '0)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tc_seen    <= 1'b0;
            we_bad     <= 1'b0;
            flush_pend <= 1'b0;
            drq        <= 1'b0;
            n_irq      <= 1'b1;
            in_ready   <= 1'b0;
            underrun   <= 1'b0;
            dir_err    <= 1'b0;
        end else begin
            tc_seen    <= tc_seen_next;
            we_bad     <= we_bad_next;
            flush_pend <= flush_pend_next;
            drq        <= drq_next;
            n_irq      <= (state_next != DMA_DONE);
            in_ready   <= (level_next != LW'(DEPTH));
            underrun   <= underrun | underrun_set;
            dir_err    <= dir_err | dir_err_set;
        end
    end

    assign data_out    = empty ? DMA_IDLE_DATA : head;
    assign data_out_en = (state == DMA_XFER) & ~n_dack & ~n_we;

endmodule

// File: tb/tb_dma_rx_endpoint.sv
// Directed bench for dma_rx_endpoint with a queue-based transaction model checked every cycle.
module tb_dma_rx_endpoint;

    localparam int DEPTH = 16;
    localparam int TH    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       drq;
    logic       n_dack;
    logic       tc;
    logic       n_we;
    logic [7:0] data_out;
    logic       data_out_en;
    logic       n_irq;
    logic       irq_clr;
    logic [4:0] level;
    logic       underrun;
    logic       dir_err;

    always #5 clk = ~clk;

    dma_rx_endpoint #(.DEPTH(DEPTH), .REQ_THRESHOLD(TH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .drq         (drq),
        .n_dack      (n_dack),
        .tc          (tc),
        .n_we        (n_we),
        .data_out    (data_out),
        .data_out_en (data_out_en),
        .n_irq       (n_irq),
        .irq_clr     (irq_clr),
        .level       (level),
        .underrun    (underrun),
        .dir_err     (dir_err)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: the FIFO is a queue, a transfer is a run of n_dack-low cycles.
    byte unsigned q[$];
    bit m_en = 0, m_released = 0, m_xfer = 0, m_done = 0, m_twe = 0, m_ttc = 0;
    bit m_under = 0, m_dir = 0, m_pend = 0, m_drq = 0;

    always @(posedge clk) begin : model
        int old_n;
        bit push_m, pop_m, enter_done;
        if (!rst) begin
            q.delete();
            m_en = 1; m_released = 0; m_xfer = 0; m_done = 0; m_twe = 0; m_ttc = 0;
            m_under = 0; m_dir = 0; m_pend = 0; m_drq = 0;
        end else begin
            old_n      = q.size();
            push_m     = in_valid && m_released && (old_n < DEPTH);
            pop_m      = 0;
            enter_done = 0;
            if (m_done) begin
                if (irq_clr) m_done = 0;
            end else if (!m_xfer) begin
                if (!n_dack) begin m_xfer = 1; m_twe = n_we; m_ttc = tc; end
            end else if (!n_dack) begin
                m_twe |= n_we; m_ttc |= tc;
            end else begin
                m_xfer = 0;
                if (old_n == 0) m_under = 1;
                if (m_twe) m_dir = 1;
                pop_m = (old_n != 0) && !m_twe;
                if (m_ttc) begin m_done = 1; enter_done = 1; end
            end
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(in_data);
            if (q.size() == 0 || enter_done) m_pend = 0;
            else if (flush && old_n != 0) m_pend = 1;
            m_drq = !m_xfer && !m_done && (q.size() >= TH || (m_pend && q.size() != 0));
            m_released = 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] ed;
        if (m_en) begin
            ed = 8'h00;
            if (q.size() != 0) ed = q[0];
            cmp("m_level",    32'(level),       32'(q.size()));
            cmp("m_in_ready", 32'(in_ready),    32'(m_released && q.size() < DEPTH));
            cmp("m_drq",      32'(drq),         32'(m_drq));
            cmp("m_n_irq",    32'(n_irq),       32'(!m_done));
            cmp("m_data_out", 32'(data_out),    32'(ed));
            cmp("m_data_en",  32'(data_out_en), 32'(m_xfer && !n_dack && !n_we));
            cmp("m_underrun", 32'(underrun),    32'(m_under));
            cmp("m_dir_err",  32'(dir_err),     32'(m_dir));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        cyc(1);
        in_valid = 1'b0;
    endtask

    // Three-cycle n_dack pulse; seen/en_seen sample the bus in the first XFER cycle.
    task automatic ack(input bit we, input int tc_at, input bit push_exit, input logic [7:0] pd,
                       output logic [7:0] seen, output logic en_seen);
        n_dack = 1'b0; n_we = we;
        for (int i = 0; i < 3; i++) begin
            tc = (tc_at == i);
            cyc(1);
            if (i == 0) begin seen = data_out; en_seen = data_out_en; end
        end
        n_dack = 1'b1; tc = 1'b0; n_we = 1'b1;
        if (push_exit) begin in_valid = 1'b1; in_data = pd; end
        cyc(1);
        in_valid = 1'b0;
    endtask

    logic [7:0] s;
    logic       e;

    initial begin
        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0;
        n_dack = 1'b1; tc = 1'b0; n_we = 1'b1; irq_clr = 1'b0;

        cyc(2);
        cmp("rst_level", 32'(level), 0);
        cmp("rst_in_ready", 32'(in_ready), 0);
        cmp("rst_drq", 32'(drq), 0);
        cmp("rst_n_irq", 32'(n_irq), 1);
        cmp("rst_data_out", 32'(data_out), 0);
        rst = 1'b1;
        cyc(1);
        cmp("release_in_ready", 32'(in_ready), 1);

        // Threshold request and in-order drain
        for (int i = 0; i < 4; i++) begin
            push_byte(8'(8'hA0 + i));
            if (i == 2) cmp("a_drq_lvl3", 32'(drq), 0);
        end
        cmp("a_level4", 32'(level), 4);
        cmp("a_drq_up", 32'(drq), 1);
        for (int i = 0; i < 4; i++) begin
            ack(1'b0, -1, 1'b0, 8'h00, s, e);
            cmp("a_data", 32'(s), 32'(8'hA0 + i));
            cmp("a_en", 32'(e), 1);
            cmp("a_drq_low", 32'(drq), 0);
        end
        cmp("a_level0", 32'(level), 0);

        // Flush of a partial FIFO
        push_byte(8'h11);
        push_byte(8'h22);
        cmp("f_drq_before", 32'(drq), 0);
        flush = 1'b1; cyc(1); flush = 1'b0;
        cmp("f_drq_flush", 32'(drq), 1);
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        cmp("f_data0", 32'(s), 32'h11);
        cmp("f_drq_still", 32'(drq), 1);
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        cmp("f_data1", 32'(s), 32'h22);
        cmp("f_drq_drained", 32'(drq), 0);
        flush = 1'b1; cyc(1); flush = 1'b0; cyc(1);
        cmp("f_empty_flush", 32'(drq), 0);

        // Terminal count on the third ack
        for (int i = 0; i < 4; i++) push_byte(8'(8'hB0 + i));
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        cmp("t_n_irq_pre", 32'(n_irq), 1);
        ack(1'b0, 1, 1'b0, 8'h00, s, e);
        cmp("t_data", 32'(s), 32'hB2);
        cmp("t_n_irq", 32'(n_irq), 0);
        cmp("t_level1", 32'(level), 1);
        cmp("t_drq", 32'(drq), 0);
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        cmp("t_done_en", 32'(e), 0);
        cmp("t_done_level", 32'(level), 1);
        irq_clr = 1'b1; cyc(1); irq_clr = 1'b0;
        cmp("t_irq_clr", 32'(n_irq), 1);
        cmp("t_drq_after_clr", 32'(drq), 0);
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
        cmp("t_drq_rerise", 32'(drq), 1);
        for (int i = 0; i < 4; i++) begin
            ack(1'b0, -1, 1'b0, 8'h00, s, e);
            cmp("t_drain", 32'(s), (i == 0) ? 32'hB3 : 32'(8'hC0 + i - 1));
        end

        // Empty FIFO and wrong-direction acks
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        cmp("u_en", 32'(e), 1);
        cmp("u_data", 32'(s), 0);
        cmp("u_flag", 32'(underrun), 1);
        cmp("u_level", 32'(level), 0);
        push_byte(8'hD0);
        ack(1'b1, -1, 1'b0, 8'h00, s, e);
        cmp("d_en", 32'(e), 0);
        cmp("d_flag", 32'(dir_err), 1);
        cmp("d_level", 32'(level), 1);
        ack(1'b0, -1, 1'b0, 8'h00, s, e);
        cmp("d_data", 32'(s), 32'hD0);

        // Fill to DEPTH, pops with concurrent pushes, reset mid-transfer
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin in_data = 8'(8'hE0 + i); cyc(1); end
        in_valid = 1'b0;
        cmp("full_level", 32'(level), 16);
        cmp("full_in_ready", 32'(in_ready), 0);
        ack(1'b0, -1, 1'b1, 8'h55, s, e);
        cmp("full_pop_data", 32'(s), 32'hE0);
        cmp("full_pop_level", 32'(level), 15);
        ack(1'b0, -1, 1'b1, 8'h66, s, e);
        cmp("pushpop_data", 32'(s), 32'hE1);
        cmp("pushpop_level", 32'(level), 15);
        n_dack = 1'b0; n_we = 1'b0;
        cyc(2);
        cmp("r_en_mid", 32'(data_out_en), 1);
        rst = 1'b0;
        cyc(1);
        cmp("r_level", 32'(level), 0);
        cmp("r_en", 32'(data_out_en), 0);
        cmp("r_drq", 32'(drq), 0);
        cmp("r_underrun", 32'(underrun), 0);
        cmp("r_dir_err", 32'(dir_err), 0);
        cmp("r_in_ready", 32'(in_ready), 0);
        n_dack = 1'b1; n_we = 1'b1; rst = 1'b1;
        cyc(2);
        cmp("r_release_ready", 32'(in_ready), 1);
        cmp("r_release_level", 32'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
